// File: rtl/uart_pkg.sv
// UART frame controller shared types.
// States, error codes and default marker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame.
// Single port: sync write, async read.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // payload bytes land here while the frame arrives
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART frame parser: sync, len, payload,
// checksum, then drain to a valid/ready sink.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxd,
  input  logic       rxv,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  state_e state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_rdata;
  logic [7:0]    csum;
  logic          counting;
  logic          xfer;

  // one address serves payload writes and drain reads
  assign buf_addr = idx_q[AW-1:0];

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .addr_i  (buf_addr),
    .wdata_i (rxd),
    .rdata_o (buf_rdata)
  );

  assign csum     = sum_q + rxd;
  assign counting = (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) ||
                    (state_q == ST_CSUM);
  assign xfer     = valid_q & out_ready;

  // next-state, datapath and pulse generation
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    tmo_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    buf_we  = 1'b0;

    if (counting && !rxv) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rxv && rxd == SYNC_BYTE) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rxv) begin
          len_d = rxd;
          sum_d = rxd;
          idx_d = '0;
          if (rxd == 8'd0 || rxd > MAX_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rxv) begin
          buf_we = 1'b1;
          sum_d  = csum;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) begin
            idx_d   = '0;
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rxv) begin
          if (csum == 8'd0) begin
            ok_d    = 1'b1;
            valid_d = 1'b1;
            data_d  = buf_rdata;
            last_d  = (len_q == 8'd1);
            idx_d   = 8'd1;
            state_d = ST_DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (rxv) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (xfer) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            data_d = buf_rdata;
            last_d = (idx_q == len_q - 8'd1);
            idx_d  = idx_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (counting && !rxv && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = ST_IDLE;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed cases
// plus random frames vs a frame-level model.
module tb_uart_frame_ctrl;

  localparam int         MAXL = 16;
  localparam int         TMO  = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxd;
  logic       rxv;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_frame_ctrl #(
    .MAX_LEN     (MAXL),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rxv       (rxv),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_rx;
  int rdy_mode = 0;

  // observed events
  int         oks[$];
  int         err_cyc[$];
  logic [1:0] err_cd[$];
  logic [8:0] xf[$];
  int         xfc[$];

  // expected events
  int         e_ok[$];
  int         e_err_cyc[$];
  logic [1:0] e_err_cd[$];
  logic [8:0] e_x[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom % 4) != 0;
    endcase
  end

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic       pl = 1'b0;
  logic [7:0] pd = 8'h0;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
      end
      if (frame_ok || frame_err)
        chk("ok_err_excl", frame_ok & frame_err, 0);
      if (frame_ok) begin
        oks.push_back(cyc);
        chk("ok_ovalid", out_valid, 1);
      end
      if (frame_err) begin
        err_cyc.push_back(cyc);
        err_cd.push_back(err_code);
      end
      if (out_valid && out_ready) begin
        xf.push_back({out_last, out_data});
        xfc.push_back(cyc);
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rxd = b;
    rxv = 1'b1;
    tick();
    last_rx = cyc;
    rxv = 1'b0;
    rxd = 8'($urandom);
  endtask

  function automatic int pick_gap(input int mg);
    if (mg == 0) return 0;
    if ($urandom % 20 == 0) return TMO - 1;
    return $urandom_range(0, mg);
  endfunction

  task automatic exp_err(input int c, input logic [1:0] cd);
    e_err_cyc.push_back(c);
    e_err_cd.push_back(cd);
  endtask

  // sends a frame; bad=1 corrupts the checksum
  task automatic frame(input int len, input bit bad,
                       input int mg);
    logic [7:0] p[$];
    logic [7:0] b;
    logic [7:0] cs;
    int s;
    s = len;
    send(SYNC, pick_gap(mg));
    send(8'(len), pick_gap(mg));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      p.push_back(b);
      s += b;
      send(b, pick_gap(mg));
    end
    cs = 8'(256 - (s % 256));
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    send(cs, pick_gap(mg));
    if (bad) begin
      exp_err(last_rx, 2'd2);
    end else begin
      e_ok.push_back(last_rx);
      for (int i = 0; i < len; i++)
        e_x.push_back({i == len - 1, p[i]});
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk("settle_busy", busy, 0);
    repeat (2) tick();
  endtask

  task automatic check_scn();
    chk("n_ok", oks.size(), e_ok.size());
    for (int i = 0; i < oks.size() && i < e_ok.size(); i++)
      chk("ok_cyc", oks[i], e_ok[i]);
    chk("n_err", err_cyc.size(), e_err_cyc.size());
    for (int i = 0; i < err_cyc.size() &&
         i < e_err_cyc.size(); i++) begin
      chk("err_cyc", err_cyc[i], e_err_cyc[i]);
      chk("err_code", err_cd[i], e_err_cd[i]);
    end
    chk("n_xfer", xf.size(), e_x.size());
    for (int i = 0; i < xf.size() && i < e_x.size(); i++)
      chk("xfer", xf[i], e_x[i]);
    oks.delete(); err_cyc.delete(); err_cd.delete();
    xf.delete(); xfc.delete();
    e_ok.delete(); e_err_cyc.delete(); e_err_cd.delete();
    e_x.delete();
  endtask

  task automatic chk_reset_outs();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int len;
    int m;
    int c0;
    logic [7:0] g;
    rst = 1'b1;
    rxv = 1'b0;
    rxd = 8'h00;
    out_ready = 1'b1;
    repeat (3) tick();
    chk_reset_outs();
    rst = 1'b0;
    tick();

    // good frame, ready held high
    rdy_mode = 0;
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0);
    send(8'h22, 0); send(8'h33, 0); send(8'h97, 0);
    c0 = last_rx;
    e_ok.push_back(c0);
    e_x.push_back({1'b0, 8'h11});
    e_x.push_back({1'b0, 8'h22});
    e_x.push_back({1'b1, 8'h33});
    settle();
    for (int i = 0; i < xfc.size(); i++)
      chk("x_cyc", xfc[i], c0 + i);
    check_scn();

    // bad checksum
    send(8'hA5, 0); send(8'h02, 0); send(8'h10, 0);
    send(8'h20, 0); send(8'h00, 0);
    exp_err(last_rx, 2'd2);
    settle();
    check_scn();

    // length errors
    send(8'hA5, 0); send(8'h00, 0);
    exp_err(last_rx, 2'd1);
    send(8'hA5, 1); send(8'h11, 0);
    exp_err(last_rx, 2'd1);
    settle();
    check_scn();

    // timeout, then a good frame
    send(8'hA5, 0); send(8'h02, 0); send(8'h55, 0);
    exp_err(last_rx + TMO, 2'd3);
    settle();
    check_scn();
    frame(5, 1'b0, 2);
    settle();
    check_scn();

    // backpressure with overrun during drain
    rdy_mode = 1;
    frame(2, 1'b0, 0);
    send(8'h5A, 1);
    exp_err(last_rx, 2'd0);
    repeat (10) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_busy", busy, 1);
    rdy_mode = 0;
    settle();
    check_scn();

    // reset mid-payload
    rdy_mode = 2;
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0);
    rst = 1'b1;
    tick();
    chk_reset_outs();
    rst = 1'b0;
    tick();
    check_scn();
    frame(4, 1'b0, 1);
    settle();
    check_scn();

    // random frames
    for (int it = 0; it < 60; it++) begin
      kind = $urandom % 10;
      if ($urandom % 3 == 0) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        send(g, $urandom_range(0, 3));
      end
      if (kind < 5) begin
        frame($urandom_range(1, MAXL), 1'b0, 3);
      end else if (kind < 7) begin
        frame($urandom_range(1, MAXL), 1'b1, 3);
      end else if (kind < 8) begin
        send(SYNC, $urandom_range(0, 3));
        len = ($urandom % 2) ? 0 : $urandom_range(MAXL + 1, 255);
        send(8'(len), pick_gap(3));
        exp_err(last_rx, 2'd1);
      end else begin
        len = $urandom_range(1, MAXL);
        m = $urandom_range(0, len + 1);
        send(SYNC, $urandom_range(0, 3));
        if (m > 0) send(8'(len), pick_gap(3));
        for (int i = 1; i < m; i++)
          send(8'($urandom), pick_gap(3));
        exp_err(last_rx + TMO, 2'd3);
      end
      settle();
      check_scn();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum payload bytes per frame, range 1..255.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 Parameter TIMEOUT_CYC, default 2048: maximum clk cycles allowed between consecutive rxv pulses inside a frame; must be >= 2.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rxd  in  8  received byte; sampled only when rxv=1.
REQ-007 rxv  in  1  one-cycle byte-valid strobe from the UART receiver.
REQ-008 out_data  out  8  payload byte.
REQ-009 out_valid  out  1  out_data is valid.
REQ-010 out_last  out  1  final payload byte of the frame; qualified by out_valid.
REQ-011 out_ready  in  1  downstream accepts the byte; a transfer occurs when out_valid=1 and out_ready=1.
REQ-012 frame_ok  out  1  one-cycle pulse when a frame passes all checks.
REQ-013 frame_err  out  1  one-cycle pulse when an error is detected.
REQ-014 err_code  out  2  error cause, held until the next frame_err: 0=OVERRUN, 1=LEN, 2=CSUM, 3=TIMEOUT.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM shall have states IDLE, LEN, PAYLOAD, CSUM and DRAIN; every transition is registered, one per clk.
REQ-017 IDLE: on rxv with rxd==SYNC_BYTE go to LEN; any other byte is silently discarded.
REQ-018 LEN: on rxv latch len=rxd and set sum=rxd; if len==0 or len>MAX_LEN, pulse frame_err, set err_code=1, and go to IDLE; otherwise go to PAYLOAD with byte index 0.
REQ-019 PAYLOAD: on each rxv, write rxd to buffer[index], set sum=sum+rxd (mod 256), and increment index; on the len-th byte go to CSUM.
REQ-020 CSUM: on rxv, if (sum+rxd) mod 256 == 0, go to DRAIN and pulse frame_ok in the cycle after the rxv; otherwise pulse frame_err, set err_code=2, and go to IDLE.
REQ-021 DRAIN: out_valid=1 from the first cycle in DRAIN; bytes are presented as buffer[0..len-1] in order; out_last=1 on buffer[len-1]; return to IDLE in the cycle after the last transfer.
REQ-022 out_data, out_valid and out_last shall hold stable while out_valid=1 and out_ready=0.
REQ-023 rxv in DRAIN: discard the byte, pulse frame_err, set err_code=0; draining continues unaffected.
REQ-024 Timeout: an idle counter clears on every rxv and counts in LEN, PAYLOAD and CSUM; when it reaches TIMEOUT_CYC, pulse frame_err, set err_code=3, and go to IDLE; it does not count in IDLE or DRAIN.
REQ-025 If rxv arrives in the same cycle the timeout is reached, the rxv wins and the counter clears.
REQ-026 Frames are accepted back-to-back; a SYNC_BYTE received in the same cycle the FSM returns to IDLE is not required to be caught.
REQ-027 A payload byte equal to SYNC_BYTE has no special meaning.
REQ-028 frame_ok and frame_err shall never be asserted in the same cycle.
REQ-029 Latency: frame_ok asserts, and the first out_valid appears, exactly 1 clk after the checksum rxv.

Reset
REQ-030 When rst=1 at a clk edge: state=IDLE; out_valid=0, out_last=0, out_data=0, frame_ok=0, frame_err=0, err_code=0, busy=0; counters and sum cleared.
REQ-031 Buffer contents are not reset.
REQ-032 rst asserted mid-frame or mid-drain shall abort the frame with no frame_err or frame_ok pulse.

Structure
REQ-033 A shared package uart_pkg shall hold the state enumeration, the err_code constants and the default SYNC_BYTE.
REQ-034 The payload store shall be a single sub-module, uart_frame_buf: a MAX_LEN x 8 single-port RAM with synchronous write and asynchronous or registered read, hidden behind the DRAIN output register.

Verification
REQ-035 Good frame: A5 03 11 22 33 97 with out_ready=1 -> frame_ok=1 once; out_data 11, 22, 33 on 3 consecutive cycles with out_last on 33; frame_err never asserted.
REQ-036 Bad checksum: A5 02 10 20 00 -> frame_err=1, err_code=2, no out_valid, busy=0 afterwards.
REQ-037 Length error: A5 00, then A5 11 with MAX_LEN=16 -> two frame_err pulses with err_code=1.
REQ-038 Timeout: A5 02 55, then no rxv for TIMEOUT_CYC cycles -> frame_err with err_code=3 exactly at the limit; a following good frame passes.
REQ-039 Backpressure and overrun: good 2-byte frame with out_ready=0 for 10 cycles, and a byte injected during DRAIN -> frame_err with err_code=0; both bytes delivered intact and in order after out_ready rises.
REQ-040 Reset mid-payload: assert rst after A5 04 01 -> all outputs at reset values; the next good frame is received correctly.
